// File: rtl/stack_sched_pkg.sv
// Shared encodings for the arbitrated hardware stack front end:
// opcodes, scheduler FSM states and requester identifiers.
package stack_sched_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_PEEK = 2'd2,
    OP_SIZE = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic REQ_EXEC = 1'b0;  // execute stage
  localparam logic REQ_CTX  = 1'b1;  // context-switch / interrupt unit

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous stack memory with one-cycle registered read data.
module stack_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_op_scheduler.sv
// Two-requester round-robin scheduler in front of a shared hardware stack.
// Optional macro STACK_WATERMARK_EN adds the high_water port and reports it in SIZE.
module stack_op_scheduler
  import stack_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [PTR_W:0]    sp,
  output logic              full,
  output logic              empty
`ifdef STACK_WATERMARK_EN
  ,
  output logic [PTR_W:0]    high_water
`endif
);

  state_t            state, state_nx;
  op_t               op;
  logic              last_grant, grant;
  logic [PTR_W:0]    sp_nx;
  logic              resp_id_nx, resp_err_nx;
  logic [DATA_W-1:0] resp_data_nx, size_word, ram_rdata;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_addr, top_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign full       = (sp == (PTR_W+1)'(DEPTH));
  assign empty      = (sp == '0);
  assign resp_valid = (state == ST_RESP);
  // Low PTR_W bits minus one wraps to DEPTH-1 when the stack is full.
  assign top_addr   = sp[PTR_W-1:0] - 1'b1;

  always_comb begin
    size_word           = '0;
    size_word[PTR_W:0]  = sp;
`ifdef STACK_WATERMARK_EN
    size_word[16 +: PTR_W+1] = high_water;
`endif
  end

  always_comb begin
    state_nx     = state;
    req_ready    = '0;
    grant        = last_grant;
    op           = OP_SIZE;
    sp_nx        = sp;
    resp_id_nx   = resp_id;
    resp_err_nx  = resp_err;
    resp_data_nx = resp_data;
    ram_we       = 1'b0;
    ram_addr     = top_addr;
    ram_wdata    = req_wdata0;

    unique case (state)
      ST_IDLE: begin
        // Accepts are suppressed while reset is held so no write can land.
        if ((req_valid != 2'b00) && !reset) begin
          if (req_valid == 2'b11)  grant = ~last_grant;
          else if (req_valid[0])   grant = REQ_EXEC;
          else                     grant = REQ_CTX;
          req_ready[grant] = 1'b1;
          op           = op_t'(grant ? req_op1 : req_op0);
          ram_wdata    = grant ? req_wdata1 : req_wdata0;
          resp_id_nx   = grant;
          resp_err_nx  = 1'b0;
          resp_data_nx = '0;
          state_nx     = ST_RESP;
          unique case (op)
            OP_PUSH: begin
              if (full) begin
                resp_err_nx = 1'b1;
              end else begin
                ram_we   = 1'b1;
                ram_addr = sp[PTR_W-1:0];
                sp_nx    = sp + 1'b1;
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty) begin
                resp_err_nx = 1'b1;
              end else begin
                state_nx = ST_READ;
                if (op == OP_POP) sp_nx = sp - 1'b1;
              end
            end
            OP_SIZE: resp_data_nx = size_word;
          endcase
        end
      end
      ST_READ: begin
        resp_data_nx = ram_rdata;
        state_nx     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sp         <= '0;
      last_grant <= REQ_CTX;
      resp_id    <= REQ_EXEC;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      sp         <= sp_nx;
      last_grant <= grant;
      resp_id    <= resp_id_nx;
      resp_data  <= resp_data_nx;
      resp_err   <= resp_err_nx;
    end
  end

`ifdef STACK_WATERMARK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_water <= '0;
    end else if (ram_we && (sp_nx > high_water)) begin
      high_water <= sp_nx;
    end
  end
`endif

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
